wb_lcd_ctrl: RTL
================

Name: wb_lcd_ctrl

Overview:
- Wishbone slave that drives an HD44780-style character LCD (E, RS, RW, Data_out) with hardware-timed bus cycles. Software no longer bit-bangs the pins.
- Software pushes command and data bytes into a FIFO.
- A timing FSM emits each byte in 8-bit or 4-bit (nibble) mode with programmable setup, enable-pulse, hold and execution-wait times.
- The block replaces the LCD port in the SoC peripheral space and raises an interrupt when the FIFO drains.

Parameters:
- CLK_FREQ, 100000000, system clock in Hz (documentation only; cycle parameters below are sized for this value)
- FIFO_DEPTH, 16, entries in the command/data FIFO (power of 2, 2..256)
- SETUP_CYC, 8, cycles RS/Data_out are stable before E rises
- E_CYC, 50, cycles E is held high
- HOLD_CYC, 8, cycles RS/Data_out are held after E falls
- CMD_WAIT_CYC, 4000, execution wait after a normal byte (40 us)
- CLR_WAIT_CYC, 160000, execution wait after clear/home commands (1.6 ms)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wb_stb_i  in  1  Wishbone strobe
- wb_cyc_i  in  1  Wishbone cycle
- wb_we_i  in  1  Wishbone write enable
- wb_adr_i  in  32  byte address; only [7:0] decoded
- wb_sel_i  in  4  byte selects (ignored; full-word access)
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  Wishbone acknowledge
- intr  out  1  interrupt, level
- E  out  1  LCD enable
- RS  out  1  LCD register select (0 = command, 1 = data)
- RW  out  1  LCD read/write, tied 0 (write-only)
- Data_out  out  8  LCD data bus

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE and the FIFO is emptied.
  - E=0, RS=0, RW=0, Data_out=0, wb_dat_o=0, ack=0, intr=0.
  - CTRL=0, all sticky bits=0.
  - Reset asserted mid-transfer aborts immediately; E drops in the same instant.
- Wishbone:
  - ack is registered; wb_ack_o = stb & cyc & ack.
  - ack rises one cycle after stb&cyc and lasts one cycle, then deasserts for at least one cycle (no back-to-back ack).
  - Reads are registered alongside ack.
  - Unmapped reads return 0; unmapped writes are ignored.
- Register map:
  - 0x00 CTRL (rw): [0] EN, [1] MODE4, [2] IRQEN, [3] FLUSH (write-only, self-clearing, reads 0).
  - 0x04 STATUS (ro): [0] BUSY (FSM not IDLE), [1] FULL, [2] EMPTY, [3] DONE, [4] OVF, [15:8] FIFO level.
  - 0x08 CMD (wo): push {RS=0, wb_dat_i[7:0]}.
  - 0x0C DATA (wo): push {RS=1, wb_dat_i[7:0]}.
  - 0x10 IRQ (w1c): bit0 write 1 clears DONE; bit1 write 1 clears OVF.
- FIFO:
  - 9-bit entries; level counts 0..FIFO_DEPTH.
  - A push while FULL is dropped and sets OVF.
  - FLUSH empties the FIFO in one cycle but does not abort the byte in flight.
  - A push and a FSM pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
  - IDLE: if EN=1 and FIFO not empty, pop the entry, latch RS and the byte, go to SETUP. If EN=0, stay in IDLE; a transfer already in flight completes.
  - SETUP: E=0, RS and Data_out driven; lasts SETUP_CYC cycles, then PULSE.
  - PULSE: E=1 for E_CYC cycles, then HOLD.
  - HOLD: E=0 for HOLD_CYC cycles. Then:
    - in MODE4 after the high nibble, go to SETUP for the low nibble;
    - otherwise go to WAIT.
  - WAIT: lasts CLR_WAIT_CYC if RS=0 and byte is 0x01, 0x02 or 0x03; otherwise CMD_WAIT_CYC. Then IDLE.
- MODE4:
  - Data_out[7:4] carries the nibble, high nibble first; Data_out[3:0]=0.
  - MODE4 is sampled at pop; changing it mid-byte has no effect on that byte.
- 8-bit mode: Data_out = byte.
- Latency: first E rise occurs 1+SETUP_CYC cycles after the pop cycle. A wait counter of at least 18 bits is required.
- DONE:
  - Set when the FSM enters IDLE from WAIT with the FIFO empty.
  - If set and clear happen in the same cycle, set wins.
- intr = IRQEN & DONE.

Test Plan:
- Reset check: hold reset=0 mid-PULSE -> E=0 immediately; STATUS reads 0x0000_0004 after release.
- 8-bit data byte: CTRL=0x1, write 0x0C=0x41 -> RS=1, Data_out=0x41 for 8 setup cycles, E high exactly 50 cycles, 8 hold cycles; BUSY clears after 4000 further cycles; DONE=1.
- 4-bit command plus clear wait: CTRL=0x3, write 0x08=0x01 -> two E pulses with Data_out=0x00 then 0x10, RS=0; WAIT lasts 160000 cycles.
- FIFO overflow: EN=0, push 17 bytes -> level=16, FULL=1, OVF=1. Write 0x10=0x2 -> OVF=0. Set EN -> 16 bytes emitted in order.
- FLUSH: enable output, push 4 bytes; during the first byte's PULSE write CTRL=0x9 -> the first byte completes and the remaining 3 are never emitted; EMPTY=1.
- Interrupt: IRQEN=1, push one byte -> intr rises when the FSM returns to IDLE. Write 0x10=0x1 -> intr=0. A push in the clear cycle does not lose the next DONE.

Source files
------------

// File: rtl/wb_lcd_ctrl_if.sv
// Wishbone slave bus bundle for the LCD controller.
// master drives strobe/cycle/address/data, slave returns data/ack.
interface wb_lcd_ctrl_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_lcd_ctrl.sv
// Wishbone HD44780 LCD controller: FIFO of cmd/data bytes + timing FSM.
// Ports: clk, reset (async low), wb slave, intr, E/RS/RW/Data_out pins.
module wb_lcd_ctrl #(
  parameter int CLK_FREQ     = 100000000,
  parameter int FIFO_DEPTH   = 16,
  parameter int SETUP_CYC    = 8,
  parameter int E_CYC        = 50,
  parameter int HOLD_CYC     = 8,
  parameter int CMD_WAIT_CYC = 4000,
  parameter int CLR_WAIT_CYC = 160000
) (
  input  logic           clk,
  input  logic           reset,
  wb_lcd_ctrl_if.slave   wb,
  output logic           intr,
  output logic           E,
  output logic           RS,
  output logic           RW,
  output logic [7:0]     Data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int M1 = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
  localparam int M2 = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int M3 = (M2 > CMD_WAIT_CYC) ? M2 : CMD_WAIT_CYC;
  localparam int M4 = (M3 > CLR_WAIT_CYC) ? M3 : CLR_WAIT_CYC;
  localparam int CW0 = $clog2(M4 + 1);
  localparam int CW = (CW0 > 18) ? CW0 : 18;
  localparam int unused_clk_freq = CLK_FREQ;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    byte_q;
  logic          rs_q;
  logic          m4_q;
  logic          lo_q;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [LW-1:0] lvl_q;

  logic [2:0]    ctrl_q;
  logic          done_q;
  logic          ovf_q;
  logic          ack_q;
  logic [31:0]   dat_q;

  logic [7:0]    adr;
  logic          req, wr, rd;
  logic          wr_ctrl, wr_irq;
  logic          push, push_ok, pop;
  logic          flush, full, empty;
  logic          busy, wait_end, is_clr;
  logic [7:0]    lvl8;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign unused_bits = ^{wb.wb_sel_i,
                         wb.wb_adr_i[31:8],
                         wb.wb_dat_i[31:8]};

  assign adr     = wb.wb_adr_i[7:0];
  assign req     = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr      = req & wb.wb_we_i;
  assign rd      = req & ~wb.wb_we_i;
  assign wr_ctrl = wr && (adr == 8'h00);
  assign wr_irq  = wr && (adr == 8'h10);
  assign push    = wr && (adr == 8'h08 || adr == 8'h0C);
  assign flush   = wr_ctrl & wb.wb_dat_i[3];

  assign full    = (lvl_q == LW'(FIFO_DEPTH));
  assign empty   = (lvl_q == '0);
  assign push_ok = push & ~full;
  assign pop     = (state_q == S_IDLE) & ctrl_q[0] & ~empty;
  assign busy    = (state_q != S_IDLE);
  assign wait_end = (state_q == S_WAIT) && (cnt_q == '0);
  assign lvl8    = 8'(lvl_q);

  // clear display / return home need the long execution wait
  assign is_clr  = ~rs_q && (byte_q[7:2] == 6'd0)
                   && (byte_q[1:0] != 2'd0);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      adr == 8'h00: rdata = {29'd0, ctrl_q};
      adr == 8'h04: rdata = {16'd0, lvl8, 3'd0, ovf_q,
                             done_q, empty, full, busy};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= rd ? rdata : '0;
    end
  end

  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_q;
  assign wb.wb_dat_o = dat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= wb.wb_dat_i[2:0];
      // a set in the same cycle as a clear wins
      done_q <= (wait_end & empty)
                | (done_q & ~(wr_irq & wb.wb_dat_i[0]));
      ovf_q  <= (push & full)
                | (ovf_q & ~(wr_irq & wb.wb_dat_i[1]));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= {adr[2], wb.wb_dat_i[7:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else if (flush) begin
      rp_q  <= wp_q;
      lvl_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop)     rp_q <= rp_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      m4_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (pop) begin
          state_q <= S_SETUP;
          cnt_q   <= CW'(SETUP_CYC - 1);
          {rs_q, byte_q} <= mem_q[rp_q];
          m4_q    <= ctrl_q[1];
          lo_q    <= 1'b0;
        end
        S_SETUP: if (cnt_q == '0) begin
          state_q <= S_PULSE;
          cnt_q   <= CW'(E_CYC - 1);
        end else cnt_q <= cnt_q - 1'b1;
        S_PULSE: if (cnt_q == '0) begin
          state_q <= S_HOLD;
          cnt_q   <= CW'(HOLD_CYC - 1);
        end else cnt_q <= cnt_q - 1'b1;
        S_HOLD: if (cnt_q == '0) begin
          if (m4_q && !lo_q) begin
            lo_q    <= 1'b1;
            state_q <= S_SETUP;
            cnt_q   <= CW'(SETUP_CYC - 1);
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= is_clr ? CW'(CLR_WAIT_CYC - 1)
                              : CW'(CMD_WAIT_CYC - 1);
          end
        end else cnt_q <= cnt_q - 1'b1;
        S_WAIT: if (cnt_q == '0) begin
          state_q <= S_IDLE;
        end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign E        = (state_q == S_PULSE);
  assign RS       = rs_q;
  assign RW       = 1'b0;
  assign Data_out = m4_q ? {(lo_q ? byte_q[3:0] : byte_q[7:4]), 4'h0}
                         : byte_q;
  assign intr     = ctrl_q[2] & done_q;

endmodule
